// File: rtl/regfile_write_arbiter_if.sv
// Bundle for the shared regfile write port: CPU writeback, peripheral
// requests/acks and the registered regfile write outputs.
interface regfile_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic                     cpu_we;
    logic [4:0]               cpu_wreg;
    logic [31:0]              cpu_wdata;
    logic                     cpu_stall;
    logic [NUM_REQ-1:0]       req;
    logic [5*NUM_REQ-1:0]     req_reg;
    logic [32*NUM_REQ-1:0]    req_data;
    logic [NUM_REQ-1:0]       ack;
    logic                     ctrl_writeEnable;
    logic [4:0]               ctrl_writeReg;
    logic [31:0]              data_writeReg;

    // Requesters and CPU side drive writes, observe grants and the regfile port.
    modport master (
        output cpu_we, cpu_wreg, cpu_wdata, req, req_reg, req_data,
        input  cpu_stall, ack, ctrl_writeEnable, ctrl_writeReg, data_writeReg
    );

    modport slave (
        input  cpu_we, cpu_wreg, cpu_wdata, req, req_reg, req_data,
        output cpu_stall, ack, ctrl_writeEnable, ctrl_writeReg, data_writeReg
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single regfile write port: CPU first, peripherals round-robin,
// with a starvation counter that forces a peripheral slot after a bounded wait.
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic                    clock,
    input logic                    ctrl_reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int unsigned     PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]      LIMIT = 8'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   rr_ptr;
    logic [7:0]         starve_cnt;

    logic               any_req;
    logic               force_c;
    logic               cpu_win;
    logic               periph_win;
    logic               found;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   rr_next;
    logic [NUM_REQ-1:0] grant_oh;

    // Grant decision for the current cycle; first set request from rr_ptr with wrap.
    always_comb begin
        any_req    = |bus.req;
        force_c    = (starve_cnt == LIMIT) && any_req;
        cpu_win    = bus.cpu_we && !force_c;
        periph_win = !cpu_win && any_req;
        found      = 1'b0;
        cand       = '0;
        grant_idx  = '0;
        grant_oh   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        rr_next = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        if (periph_win && !ctrl_reset) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign bus.ack       = grant_oh;
    assign bus.cpu_stall = periph_win && bus.cpu_we && !ctrl_reset;

    // Registered write port, round-robin pointer and starvation counter.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            bus.ctrl_writeEnable <= 1'b0;
            bus.ctrl_writeReg    <= '0;
            bus.data_writeReg    <= '0;
            rr_ptr               <= '0;
            starve_cnt           <= '0;
        end else begin
            if (cpu_win) begin
                bus.ctrl_writeEnable <= 1'b1;
                bus.ctrl_writeReg    <= bus.cpu_wreg;
                bus.data_writeReg    <= bus.cpu_wdata;
            end else if (periph_win) begin
                bus.ctrl_writeEnable <= 1'b1;
                bus.ctrl_writeReg    <= bus.req_reg[32'(grant_idx)*5 +: 5];
                bus.data_writeReg    <= bus.req_data[32'(grant_idx)*32 +: 32];
            end else begin
                bus.ctrl_writeEnable <= 1'b0;
            end

            if (periph_win) begin
                rr_ptr     <= rr_next;
                starve_cnt <= '0;
            end else if (!any_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between the processor writeback stage and up to NUM_REQ hardware requesters, such as the goal detector posting scores or game-state logic posting LED flags. The CPU has priority. Peripherals are served round-robin, and a starvation counter forces a peripheral slot after a bounded wait. The block sits directly in front of the regfile's `ctrl_writeEnable` / `ctrl_writeReg` / `data_writeReg` inputs.

## Interface
- NUM_REQ, 4, number of peripheral requesters (1..8)
- STARVE_LIMIT, 8, CPU-won cycles a pending peripheral tolerates before preempting (1..255)
- clock  in  1  system clock, all state on rising edge
- ctrl_reset  in  1  synchronous, active-high reset
- cpu_we  in  1  CPU writeback valid
- cpu_wreg  in  5  CPU destination register
- cpu_wdata  in  32  CPU write data
- cpu_stall  out  1  combinational; CPU must hold `cpu_we` / `cpu_wreg` / `cpu_wdata` next cycle
- req  in  NUM_REQ  per-requester write request, level, held until acked
- req_reg  in  5*NUM_REQ  destination register, requester i at bits [5i+4:5i]
- req_data  in  32*NUM_REQ  write data, requester i at bits [32i+31:32i]
- ack  out  NUM_REQ  combinational one-hot grant pulse
- ctrl_writeEnable  out  1  registered regfile write enable
- ctrl_writeReg  out  5  registered regfile write address
- data_writeReg  out  32  registered regfile write data

## Operation
- State:
  - `rr_ptr`: index of the highest-priority peripheral.
  - `starve_cnt`: 8 bits.
  - Registered write outputs.
- Arbitration each cycle:
  - `force = (starve_cnt == STARVE_LIMIT) && |req`.
  - If `cpu_we && !force`: the CPU wins. No `ack`, `cpu_stall = 0`.
  - Else if `|req`: the peripheral winner is the first set `req` bit searching from `rr_ptr` upward with wrap. Its `ack` bit is 1 and `cpu_stall = cpu_we`.
  - Else: idle, nothing granted.
- Winner's register and data are registered onto the write outputs at the next edge. `ctrl_writeEnable` is 1 for any grant, including writes to register 0 (the regfile ignores them).
- Round-robin: on a peripheral grant to index g, `rr_ptr <= (g+1) mod NUM_REQ`. Otherwise `rr_ptr` holds.
- Starvation counter:
  - `|req` and the CPU wins: increment, saturating at STARVE_LIMIT.
  - Any peripheral grant: clear to 0.
  - `req == 0`: clear to 0.
- Requester contract:
  - Sample `ack` at the clock edge.
  - If acked, drop `req` or present the next write in the following cycle.
  - `req_reg` / `req_data` are stable whenever `req` is high.
- CPU contract: when `cpu_stall` is 1, the same write is re-presented next cycle. It wins then, because `starve_cnt` was just cleared.
- Reset (`ctrl_reset = 1` at an edge): `ctrl_writeEnable = 0`, `ctrl_writeReg = 0`, `data_writeReg = 0`, `rr_ptr = 0`, `starve_cnt = 0`.
- While `ctrl_reset` is high: `ack` and `cpu_stall` are forced to 0.
- A request pending at reset is not acked. It is re-arbitrated after reset deasserts.

## Timing
- Grant decision is combinational in cycle t. `ack` and `cpu_stall` are valid in cycle t.
- Write appears on the regfile port in cycle t+1. The regfile captures it at the end of t+1, so it is readable in t+2.
- Throughput: one write per cycle, no bubbles between back-to-back grants.
- Worst-case peripheral latency under continuous CPU writes and all requesters active: (STARVE_LIMIT+1)·NUM_REQ cycles.
- Simultaneous `cpu_we` and `force`: peripheral wins, `cpu_stall = 1` for exactly one cycle.
- `NUM_REQ = 1`: `rr_ptr` stays at 0.

## Test plan
- Reset then idle:
  - Stimulus: `cpu_we = 0`, `req = 0`.
  - Required: all outputs 0 for 10 cycles.
  - Stimulus: assert `ctrl_reset` mid-stream while `req = 4'b0010`.
  - Required: no `ack` while reset is high. After release, `ack = 4'b0010` next cycle, `rr_ptr` restarts at 0.
- CPU-only:
  - Stimulus: `cpu_we = 1`, `cpu_wreg = 7`, `cpu_wdata = 0xDEADBEEF`.
  - Required: `ctrl_writeEnable = 1`, `ctrl_writeReg = 7`, `data_writeReg = 0xDEADBEEF` one cycle later, `cpu_stall = 0`.
- Round-robin fairness:
  - Stimulus: `req = 4'b1111` held, each requester re-requesting after ack, `cpu_we = 0`.
  - Required: `ack` sequence 0001, 0010, 0100, 1000, 0001. Each write carries that requester's `req_reg` / `req_data`.
- Starvation preempt:
  - Stimulus: `STARVE_LIMIT = 8`, `cpu_we = 1` every cycle, `req[2]` (reg 1, data 5) asserted at cycle 0.
  - Required: CPU wins cycles 0–7. Cycle 8 gives `ack = 4'b0100` and `cpu_stall = 1`. Cycle 9 shows `ctrl_writeReg = 1`, `data_writeReg = 5`. Cycle 9 also grants the held CPU write.
- Counter clear:
  - Stimulus: `req` dropped after 5 CPU-won cycles, then reasserted.
  - Required: a full 8 further CPU-won cycles before preemption.
- Register 0:
  - Stimulus: peripheral write to `req_reg = 0`.
  - Required: acked, `ctrl_writeEnable = 1` with `ctrl_writeReg = 0`, and register 0 in the regfile stays 0.
